// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing one CSR memory port between NREQ requesters.
// Each access takes a fixed three-cycle sequence: accept, CSR access, response.
module csr_bus_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_wen,
  input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NREQ*STRB_WIDTH-1:0]     req_strb,
  input  logic [NREQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           cs,
  output logic                           wen,
  output logic [ADDR_WIDTH-1:0]          addr,
  output logic [STRB_WIDTH-1:0]          strb,
  output logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH-1:0]          rdata,
  output logic                           busy
);

  localparam int unsigned IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [IDXW-1:0]         last_grant;
  logic [IDXW-1:0]         gnt_idx;
  logic [IDXW-1:0]         winner;
  logic                    found;
  logic                    sel_wen;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [STRB_WIDTH-1:0]   sel_strb;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Rotating priority: indices above last_grant first, then wrap to the low indices.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDXW'(i) > last_grant)) begin
        found  = 1'b1;
        winner = IDXW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDXW'(i) <= last_grant)) begin
        found  = 1'b1;
        winner = IDXW'(i);
      end
    end
  end

  // Payload of the winning requester.
  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_strb  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (found && (winner == IDXW'(i))) begin
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Accept is combinational so the requester sees it in the arbitration cycle.
  always_comb begin
    req_ready = '0;
    if (rstn && (state == IDLE) && found) begin
      req_ready = NREQ'(1) << winner;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (found) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CSR port and response registers; addr/strb/wdata hold between accesses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs         <= 1'b0;
      wen        <= 1'b0;
      addr       <= '0;
      strb       <= '0;
      wdata      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      gnt_idx    <= '0;
      last_grant <= IDXW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cs         <= 1'b1;
            wen        <= sel_wen;
            addr       <= sel_addr;
            strb       <= sel_strb;
            wdata      <= sel_wdata;
            gnt_idx    <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
          end else begin
            cs  <= 1'b0;
            wen <= 1'b0;
          end
        end
        ACCESS: begin
          rsp_rdata <= wen ? DATA_WIDTH'(0) : rdata;
          cs        <= 1'b0;
          wen       <= 1'b0;
          rsp_valid <= NREQ'(1) << gnt_idx;
        end
        RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
        end
        default: begin
          cs        <= 1'b0;
          wen       <= 1'b0;
          rsp_valid <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Randomized scoreboard bench for csr_bus_arbiter with a CSR memory model.
// Expected grant order and data come from a round-robin reference model.
module tb_csr_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SW   = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_wen;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*SW-1:0]   req_strb;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 cs;
  logic                 wen;
  logic [AW-1:0]        addr;
  logic [SW-1:0]        strb;
  logic [DW-1:0]        wdata;
  logic [DW-1:0]        rdata;
  logic                 busy;

  csr_bus_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs(cs), .wen(wen), .addr(addr), .strb(strb), .wdata(wdata),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        wen;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  int   since = 3;
  int   m_lg  = NREQ - 1;
  logic mon_en = 1'b0;

  logic        p_wen   [NREQ];
  logic [15:0] p_addr  [NREQ];
  logic [3:0]  p_strb  [NREQ];
  logic [31:0] p_wdata [NREQ];

  logic [31:0] csr_mem [16] = '{32'hA5A50002, 32'hA5A50003, 32'hA5A50004, 32'hA5A50005,
                                32'hA5A50006, 32'hA5A50007, 32'hA5A50008, 32'hA5A50009,
                                32'hA5A5000A, 32'hA5A5000B, 32'hA5A5000C, 32'hA5A5000D,
                                32'hA5A5000E, 32'hA5A5000F, 32'hA5A50010, 32'hA5A50011};
  logic [31:0] ref_mem [16] = '{32'hA5A50002, 32'hA5A50003, 32'hA5A50004, 32'hA5A50005,
                                32'hA5A50006, 32'hA5A50007, 32'hA5A50008, 32'hA5A50009,
                                32'hA5A5000A, 32'hA5A5000B, 32'hA5A5000C, 32'hA5A5000D,
                                32'hA5A5000E, 32'hA5A5000F, 32'hA5A50010, 32'hA5A50011};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // CSR block: combinational read, byte-strobed write at the access edge.
  assign rdata = csr_mem[addr[5:2]];
  always @(posedge clk) if (cs && wen) csr_mem[addr[5:2]] <= merge(csr_mem[addr[5:2]], wdata, strb);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending set is served in rotating order starting after the last grant.
  task automatic model_round(input logic [NREQ-1:0] mask);
    exp_t e;
    int   base;
    int   i;
    base = m_lg;
    for (int k = 1; k <= NREQ; k++) begin
      i = (base + k) % NREQ;
      if (mask[i]) begin
        e.idx   = i;
        e.wen   = p_wen[i];
        e.addr  = p_addr[i];
        e.strb  = p_strb[i];
        e.wdata = p_wdata[i];
        if (e.wen) begin
          ref_mem[e.addr[5:2]] = merge(ref_mem[e.addr[5:2]], e.wdata, e.strb);
          e.rdata = 32'h0;
        end else begin
          e.rdata = ref_mem[e.addr[5:2]];
        end
        exp_q.push_back(e);
        m_lg = i;
      end
    end
  endtask

  task automatic rand_pay(input int i);
    p_wen[i]   = 1'($urandom_range(0, 1));
    p_addr[i]  = 16'($urandom_range(0, 15) << 2);
    p_strb[i]  = 4'($urandom);
    p_wdata[i] = $urandom;
  endtask

  task automatic set_req(input int i);
    req_wen[i]              = p_wen[i];
    req_addr[i*AW +: AW]    = p_addr[i];
    req_strb[i*SW +: SW]    = p_strb[i];
    req_wdata[i*DW +: DW]   = p_wdata[i];
    req_valid[i]            = 1'b1;
  endtask

  task automatic launch(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) if (mask[i]) set_req(i);
    model_round(mask);
  endtask

  // Hold every pending request until its ready is seen, bounded.
  task automatic serve_all();
    logic [NREQ-1:0] got;
    int cyc;
    cyc = 0;
    while (req_valid != '0 && cyc < 60) begin
      @(negedge clk);
      got = req_ready & req_valid;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~got;
      cyc++;
    end
    chk("serve_timeout", 32'(req_valid), 32'h0);
    req_valid = '0;
  endtask

  task automatic wait_ready(input int i);
    int cyc;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (req_ready[i]) break;
      cyc++;
    end
    chk("ready_timeout", 32'(cyc < 20), 32'h1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  // Monitor: cycle-accurate protocol and data checks against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (since < 100) since++;
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($countones(req_ready)), 32'h1);
        chk("ready_spacing", 32'(since >= 3), 32'h1);
        if (exp_q.size() == 0) begin
          chk("ready_unexpected", 32'(req_ready), 32'h0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_idx", req_ready[1] ? 32'h1 : 32'h0, 32'(cur.idx));
        end
        since = 0;
      end
      chk("cs_timing", 32'(cs), 32'(since == 1));
      chk("busy", 32'(busy), 32'((since == 1) || (since == 2)));
      chk("wen_without_cs", 32'(wen && !cs), 32'h0);
      if (cs && since == 1) begin
        chk("csr_wen", 32'(wen), 32'(cur.wen));
        chk("csr_addr", 32'(addr), 32'(cur.addr));
        if (cur.wen) begin
          chk("csr_strb", 32'(strb), 32'(cur.strb));
          chk("csr_wdata", wdata, cur.wdata);
        end
      end
      if (since == 2) begin
        chk("rsp_valid", 32'(rsp_valid), 32'h1 << cur.idx);
        chk("rsp_rdata", rsp_rdata, cur.rdata);
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 32'h0);
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_strb  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_cs", 32'(cs), 32'h0);
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_strb", 32'(strb), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Directed read then write.
    p_wen[0] = 1'b0; p_addr[0] = 16'h0004; p_strb[0] = 4'h0; p_wdata[0] = 32'h0;
    launch(2'b01);
    serve_all();
    p_wen[1] = 1'b1; p_addr[1] = 16'h0008; p_strb[1] = 4'b0001; p_wdata[1] = 32'h0000_0005;
    launch(2'b10);
    serve_all();

    // Contention: both requesters continuously valid.
    for (int r = 0; r < 4; r++) begin
      rand_pay(0); rand_pay(1);
      launch(2'b11);
      serve_all();
    end

    // Late arrival during an access.
    repeat (4) @(posedge clk);
    #1;
    rand_pay(0);
    launch(2'b01);
    wait_ready(0);
    rand_pay(0); rand_pay(1);
    launch(2'b11);
    serve_all();

    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, 3));
      rand_pay(0); rand_pay(1);
      launch(m);
      serve_all();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset in the middle of an access.
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;
    p_wen[0] = 1'b0; p_addr[0] = 16'h000C; p_strb[0] = 4'h0; p_wdata[0] = 32'h0;
    set_req(0);
    wait_ready(0);
    #2;
    chk("acc_cs", 32'(cs), 32'h1);
    #1;
    req_valid = 2'b11;
    rstn      = 1'b0;
    #1;
    chk("arst_cs", 32'(cs), 32'h0);
    chk("arst_wen", 32'(wen), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req_valid = '0;
    exp_q.delete();
    since = 3;
    m_lg  = NREQ - 1;
    rand_pay(0); rand_pay(1);
    launch(2'b11);
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    serve_all();

    for (int r = 0; r < 6; r++) begin
      rand_pay(0); rand_pay(1);
      launch(NREQ'($urandom_range(1, 3)));
      serve_all();
    end

    repeat (6) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
